// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// conv2d_stream_engine : streaming 1x1/3x3 conv, zero pad, stride 1/2, valid/ready.
// Kernel packing: w0 in i_kernel_w[DATA_WIDTH-1:0]. Revision 1.0
// ============================================================================
module conv2d_stream_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WIDTH  = 416,
  parameter int MAX_HEIGHT = 416,
  parameter int DIM_W      = 9,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [DIM_W-1:0]              i_width,
  input  logic [DIM_W-1:0]              i_height,
  input  logic                          i_k3,
  input  logic                          i_pad,
  input  logic                          i_stride2,
  input  logic [9*DATA_WIDTH-1:0]       i_kernel_w,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic signed [ACC_WIDTH-1:0]   o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t state_q, state_d;
  logic [DIM_W-1:0] gw_q, gh_q, vx_q, vy_q;
  logic k3_q, pad_q, s2_q;
  logic signed [DATA_WIDTH-1:0] wt_q  [9];
  logic signed [DATA_WIDTH-1:0] win_q [9];
  logic signed [DATA_WIDTH-1:0] win_d [9];
  logic signed [DATA_WIDTH-1:0] lb0_q [MAX_WIDTH+2];
  logic signed [DATA_WIDTH-1:0] lb1_q [MAX_WIDTH+2];
  logic signed [ACC_WIDTH-1:0]  out_data_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic out_valid_q, done_q, done_d;

  logic [DIM_W-1:0] k_in, gw_in, gh_in, gw_m1, gh_m1;
  logic cfg_empty, stall, pad_pos, step, last_pos, emit, win_ok, stride_ok;
  logic signed [DATA_WIDTH-1:0] pix;

  assign k_in  = i_k3 ? DIM_W'(3) : DIM_W'(1);
  assign gw_in = i_pad ? i_width  + DIM_W'(2) : i_width;
  assign gh_in = i_pad ? i_height + DIM_W'(2) : i_height;
  assign cfg_empty = (i_width == '0) || (i_height == '0) ||
                     (i_width > DIM_W'(MAX_WIDTH)) || (i_height > DIM_W'(MAX_HEIGHT)) ||
                     (!i_pad && ((i_width < k_in) || (i_height < k_in)));

  assign gw_m1    = gw_q - DIM_W'(1);
  assign gh_m1    = gh_q - DIM_W'(1);
  assign stall    = out_valid_q & ~i_ready;
  assign pad_pos  = pad_q & ((vx_q == '0) || (vy_q == '0) || (vx_q == gw_m1) || (vy_q == gh_m1));
  assign step     = (state_q == S_RUN) & ~stall & (pad_pos | i_valid);
  assign last_pos = (vx_q == gw_m1) && (vy_q == gh_m1);
  // Parity of (v-(K-1)) equals parity of v for K in {1,3}
  assign win_ok    = ~k3_q | ((vx_q >= DIM_W'(2)) && (vy_q >= DIM_W'(2)));
  assign stride_ok = ~s2_q | (~vx_q[0] & ~vy_q[0]);
  assign emit      = step & win_ok & stride_ok;
  assign pix       = pad_pos ? '0 : i_data;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r*3]   = win_q[r*3+1];
      win_d[r*3+1] = win_q[r*3+2];
    end
    win_d[2] = lb0_q[vx_q];
    win_d[5] = lb1_q[vx_q];
    win_d[8] = pix;
    acc_d = '0;
    prod  = '0;
    if (k3_q) begin
      for (int i = 0; i < 9; i++) begin
        prod  = wt_q[i] * win_d[i];
        acc_d = acc_d + ACC_WIDTH'(prod);
      end
    end else begin
      prod  = wt_q[0] * pix;
      acc_d = ACC_WIDTH'(prod);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = cfg_empty ? S_DRAIN : S_RUN;
      S_RUN:   if (step && last_pos) state_d = S_DRAIN;
      S_DRAIN: if (!out_valid_q || i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      gw_q <= '0; gh_q <= '0; vx_q <= '0; vy_q <= '0;
      k3_q <= 1'b0; pad_q <= 1'b0; s2_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        wt_q[i]  <= '0;
        win_q[i] <= '0;
      end
      for (int i = 0; i < MAX_WIDTH+2; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == S_IDLE && i_start) begin
        gw_q  <= gw_in;
        gh_q  <= gh_in;
        k3_q  <= i_k3;
        pad_q <= i_pad;
        s2_q  <= i_stride2;
        vx_q  <= '0;
        vy_q  <= '0;
        for (int i = 0; i < 9; i++) wt_q[i] <= i_kernel_w[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (step) begin
        for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
        lb0_q[vx_q] <= lb1_q[vx_q];
        lb1_q[vx_q] <= pix;
        // Column wrap drops stale window columns via the vx>=K-1 emit gate
        if (vx_q == gw_m1) begin
          vx_q <= '0;
          vy_q <= vy_q + DIM_W'(1);
        end else begin
          vx_q <= vx_q + DIM_W'(1);
        end
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_d;
      end else if (i_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign o_ready = (state_q == S_RUN) & ~stall & ~pad_pos;
  assign o_data  = out_data_q;
  assign o_valid = out_valid_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// tb_conv2d_stream_engine : directed scenarios with hand-computed window sums.
// Revision 1.0
// ============================================================================
module tb_conv2d_stream_engine;

  localparam int DW = 16;
  localparam int AW = 2*DW+4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_start = 1'b0;
  logic [8:0] i_width = '0, i_height = '0;
  logic i_k3 = 1'b0, i_pad = 1'b0, i_stride2 = 1'b0;
  logic [9*DW-1:0] i_kernel_w = '0;
  logic signed [DW-1:0] i_data = '0;
  logic i_valid = 1'b0;
  logic o_ready;
  logic signed [AW-1:0] o_data;
  logic o_valid;
  logic i_ready = 1'b1;
  logic o_busy, o_done;

  conv2d_stream_engine dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
    .i_k3(i_k3), .i_pad(i_pad), .i_stride2(i_stride2), .i_kernel_w(i_kernel_w),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int vec = 0;
  int err = 0;
  logic signed [DW-1:0] pix_mem [0:255];
  logic signed [AW-1:0] got_q [$];
  int done_cnt, timeout_flag, stable_bad;

  function automatic logic [9*DW-1:0] mk_kw(input int w0, input int rest);
    logic [9*DW-1:0] k;
    k = '0;
    for (int i = 0; i < 9; i++) k[i*DW +: DW] = (i == 0) ? DW'(w0) : DW'(rest);
    return k;
  endfunction

  task automatic run_frame(input int w, input int h, input bit k3, input bit pad, input bit s2,
                           input logic [9*DW-1:0] kw, input int npix, input bit gaps,
                           input int stall_at, input int abort_at);
    int idx, post, stall_left;
    bit done_seen, stall_used;
    logic signed [AW-1:0] held;
    got_q.delete();
    done_cnt = 0; timeout_flag = 0; stable_bad = 0;
    idx = 0; post = 0; stall_left = 0; done_seen = 0; stall_used = 0; held = '0;
    @(negedge i_clk);
    i_width = 9'(w); i_height = 9'(h); i_k3 = k3; i_pad = pad; i_stride2 = s2;
    i_kernel_w = kw; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (stall_left == 0 && !stall_used && stall_at >= 0 && got_q.size() == stall_at && o_valid) begin
        stall_left = 5; stall_used = 1; held = o_data;
      end
      i_ready = (stall_left == 0);
      i_valid = (idx < npix) && !(gaps && $urandom_range(0, 2) == 0);
      i_data  = (idx < npix) ? pix_mem[idx] : '0;
      #1;
      if (stall_left > 0) begin
        if (o_data !== held || o_valid !== 1'b1) stable_bad++;
        stall_left--;
      end
      if (i_valid && o_ready) idx++;
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_done) done_cnt++;
      if (done_seen) post++;
      if (o_done) done_seen = 1;
      if (abort_at > 0 && got_q.size() == abort_at) break;
      if (post >= 5) break;
      @(negedge i_clk);
    end
    if (!done_seen && abort_at == 0) timeout_flag = 1;
    i_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  task automatic check_outputs(input string name, input int n, input int exp [16]);
    logic signed [AW-1:0] g, e;
    vec++;
    if (got_q.size() != n) begin
      err++; $display("FAIL %s count: got %0d expected %0d", name, got_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      e = exp[i];
      vec++;
      if (g !== e) begin
        err++; $display("FAIL %s out[%0d]: got %0d expected %0d", name, i, g, e);
      end
    end
    vec++;
    if (done_cnt != 1 || timeout_flag != 0) begin
      err++; $display("FAIL %s done: got %0d pulses (timeout=%0d) expected 1", name, done_cnt, timeout_flag);
    end
  endtask

  task automatic test_reset();
    vec++; if (o_ready !== 1'b0) begin err++; $display("FAIL reset o_ready: got %b expected 0", o_ready); end
    vec++; if (o_valid !== 1'b0) begin err++; $display("FAIL reset o_valid: got %b expected 0", o_valid); end
    vec++; if (o_data  !== '0)   begin err++; $display("FAIL reset o_data: got %0d expected 0", o_data); end
    vec++; if (o_busy  !== 1'b0) begin err++; $display("FAIL reset o_busy: got %b expected 0", o_busy); end
    vec++; if (o_done  !== 1'b0) begin err++; $display("FAIL reset o_done: got %b expected 0", o_done); end
  endtask

  task automatic test_pad3x3();
    int exp [16] = '{4,6,6,4, 6,9,9,6, 6,9,9,6, 4,6,6,4};
    for (int i = 0; i < 16; i++) pix_mem[i] = 16'sd1;
    run_frame(4, 4, 1, 1, 0, mk_kw(1, 1), 16, 0, -1, 0);
    check_outputs("pad3x3", 16, exp);
  endtask

  task automatic test_valid3x3(input string name, input bit gaps, input int stall_at);
    int exp [16] = '{45,54,81,90, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    for (int i = 0; i < 16; i++) pix_mem[i] = DW'(i);
    run_frame(4, 4, 1, 0, 0, mk_kw(1, 1), 16, gaps, stall_at, 0);
    check_outputs(name, 4, exp);
    vec++;
    if (stable_bad != 0) begin
      err++; $display("FAIL %s stall_stable: got %0d unstable cycles expected 0", name, stable_bad);
    end
  endtask

  task automatic test_stride2();
    int exp [16] = '{4,6,6,9, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    for (int i = 0; i < 16; i++) pix_mem[i] = 16'sd1;
    run_frame(4, 4, 1, 1, 1, mk_kw(1, 1), 16, 0, -1, 0);
    check_outputs("stride2", 4, exp);
  endtask

  task automatic test_1x1();
    int exp [16];
    for (int i = 0; i < 16; i++) exp[i] = (i < 9) ? -3 * (i + 1) : 0;
    for (int i = 0; i < 9; i++) pix_mem[i] = DW'(i + 1);
    run_frame(3, 3, 0, 0, 0, mk_kw(-3, 7), 9, 0, -1, 0);
    check_outputs("conv1x1", 9, exp);
    exp[0] = -1073709056;
    pix_mem[0] = 16'sh8000;
    run_frame(1, 1, 0, 0, 0, mk_kw(32'h7FFF, 5), 1, 0, -1, 0);
    check_outputs("fullprec", 1, exp);
  endtask

  task automatic test_empty();
    bit rdy_seen;
    rdy_seen = 0;
    @(negedge i_clk);
    i_width = 9'd0; i_height = 9'd4; i_k3 = 1'b1; i_pad = 1'b0; i_valid = 1'b1; i_start = 1'b1;
    #1; rdy_seen = rdy_seen | o_ready;
    @(negedge i_clk);
    i_start = 1'b0;
    #1; rdy_seen = rdy_seen | o_ready;
    vec++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      err++; $display("FAIL empty drain: got done=%b busy=%b expected done=0 busy=1", o_done, o_busy);
    end
    @(negedge i_clk);
    #1; rdy_seen = rdy_seen | o_ready;
    vec++; if (o_done !== 1'b1) begin err++; $display("FAIL empty done: got %b expected 1", o_done); end
    @(negedge i_clk);
    #1;
    vec++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      err++; $display("FAIL empty idle: got done=%b busy=%b expected 0 0", o_done, o_busy);
    end
    vec++; if (rdy_seen !== 1'b0) begin err++; $display("FAIL empty o_ready: got 1 expected 0"); end
    i_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    for (int i = 0; i < 16; i++) pix_mem[i] = 16'sd1;
    run_frame(4, 4, 1, 1, 0, mk_kw(1, 1), 16, 0, -1, 7);
    vec++; if (got_q.size() != 7) begin err++; $display("FAIL midreset pre: got %0d outputs expected 7", got_q.size()); end
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    vec++; if (o_valid !== 1'b0 || o_data !== '0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
      err++; $display("FAIL midreset clear: got valid=%b data=%0d busy=%b ready=%b expected 0", o_valid, o_data, o_busy, o_ready);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk); #1;
      if (o_done !== 1'b0 || o_valid !== 1'b0) bad = 1;
    end
    vec++; if (bad) begin err++; $display("FAIL midreset quiet: got done/valid activity expected none"); end
    test_valid3x3("after_reset", 0, -1);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    #1;
    test_reset();
    i_rst = 1'b0;
    test_pad3x3();
    test_valid3x3("valid3x3", 0, -1);
    test_stride2();
    test_1x1();
    test_empty();
    test_valid3x3("gaps_stall", 1, 1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
`default_nettype wire
